pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 10 +
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg_sat_cnt.sv | 19 +
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults for the pipeline stage register: field widths and the bubble payload.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [DATA_W_DEF-1:0] BUBBLE_DATA = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage; the stage itself uses the slave modport.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_pc, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_data
  );

  modport slave (
    input  in_valid, in_pc, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating up-counter: sticks at all-ones, clears on synchronous reset.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// One-cycle pipeline stage register with flush, bubble insertion and stall counter.
// Define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              mainValid;
  logic [PC_W-1:0]   mainPc;
  logic [DATA_W-1:0] mainData;
  logic              accept;
  logic              consume;
  logic              stallInc;

  assign consume  = mainValid & bus.out_ready;
  assign stallInc = mainValid & ~bus.out_ready & ~flush;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              skidValid;
  logic [PC_W-1:0]   skidPc;
  logic [DATA_W-1:0] skidData;
  logic              readyQ;

  // readyQ mirrors "skid empty"; flush/reset gating keeps out_ready off this path.
  assign bus.in_ready = readyQ & ~flush & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mainValid <= 1'b0;
      mainPc    <= '0;
      mainData  <= '0;
      skidValid <= 1'b0;
      skidPc    <= '0;
      skidData  <= '0;
      readyQ    <= 1'b1;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainData  <= DATA_W'(BUBBLE_DATA);
      skidValid <= 1'b0;
      skidData  <= DATA_W'(BUBBLE_DATA);
      readyQ    <= 1'b1;
    end else if (!mainValid || consume) begin
      if (skidValid) begin
        mainValid <= 1'b1;
        mainPc    <= skidPc;
        mainData  <= skidData;
        skidValid <= 1'b0;
        skidData  <= DATA_W'(BUBBLE_DATA);
        readyQ    <= 1'b1;
      end else if (accept) begin
        mainValid <= 1'b1;
        mainPc    <= bus.in_pc;
        mainData  <= bus.in_data;
      end else begin
        mainValid <= 1'b0;
        mainData  <= DATA_W'(BUBBLE_DATA);
      end
    end else if (accept) begin
      skidValid <= 1'b1;
      skidPc    <= bus.in_pc;
      skidData  <= bus.in_data;
      readyQ    <= 1'b0;
    end
  end
`else
  assign bus.in_ready = ~reset & ~flush & (~mainValid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mainValid <= 1'b0;
      mainPc    <= '0;
      mainData  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainData  <= DATA_W'(BUBBLE_DATA);
    end else if (accept) begin
      mainValid <= 1'b1;
      mainPc    <= bus.in_pc;
      mainData  <= bus.in_data;
    end else if (consume) begin
      // Bubble keeps the last PC visible for EPC capture.
      mainValid <= 1'b0;
      mainData  <= DATA_W'(BUBBLE_DATA);
    end
  end
`endif

  assign bus.out_valid = mainValid;
  assign bus.out_pc    = mainPc;
  assign bus.out_data  = mainData;

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallInc),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors, queue-based output monitor.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] stall1;
  logic [3:0]  stall2;
  logic        monOn = 1'b0;
  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;
  ent_t        sb[$];

  pipe_stage_reg_if #(.DATA_W(32), .PC_W(32)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(32), .PC_W(32)) bus2 ();

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus1),
    .stall_cnt (stall1)
  );

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .bus       (bus2),
    .stall_cnt (stall2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] data);
    bus1.in_valid = 1'b1;
    bus1.in_pc    = pc;
    bus1.in_data  = data;
    sb.push_back('{pc: pc, data: data});
  endtask

  // Monitor: every presented entry must match the scoreboard head, popped on consume.
  always @(negedge clk) begin
    if (monOn) begin
      if (bus1.out_valid) begin
        if (sb.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_out: got pc %h data %h expected no entry", bus1.out_pc, bus1.out_data);
        end else begin
          chk("mon_pc", 64'(bus1.out_pc), 64'(sb[0].pc));
          chk("mon_data", 64'(bus1.out_data), 64'(sb[0].data));
          if (bus1.out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("bubble_data", 64'(bus1.out_data), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_pc = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_pc = '0; bus2.in_data = '0; bus2.out_ready = 1'b0;

    tick();
    chk("rst_in_ready", 64'(bus1.in_ready), 64'h0);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'h0);
    chk("rst_out_data", 64'(bus1.out_data), 64'h0);
    chk("rst_out_pc", 64'(bus1.out_pc), 64'h0);
    chk("rst_stall", 64'(stall1), 64'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus1.in_ready), 64'h1);
    monOn = 1'b1;

    // First transaction, one-cycle latency then bubble with PC retained.
    bus1.out_ready = 1'b1;
    send(32'h3000, 32'hDEADBEEF);
    tick();
    bus1.in_valid = 1'b0;
    chk("lat_valid", 64'(bus1.out_valid), 64'h1);
    chk("lat_pc", 64'(bus1.out_pc), 64'h3000);
    chk("lat_data", 64'(bus1.out_data), 64'hDEADBEEF);
    tick();
    chk("bubble_valid", 64'(bus1.out_valid), 64'h0);
    chk("bubble_pc", 64'(bus1.out_pc), 64'h3000);

    // Back-to-back stream: replacement with no bubble.
    for (int i = 0; i < 3; i++) begin
      send(32'h4000 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      tick();
      chk("stream_valid", 64'(bus1.out_valid), 64'h1);
      chk("stream_pc", 64'(bus1.out_pc), 64'h4000 + 64'(4 * i));
    end
    bus1.in_valid = 1'b0;
    tick();
    chk("stream_end", 64'(bus1.out_valid), 64'h0);

    // Stall for five cycles.
    bus1.out_ready = 1'b0;
    send(32'h3004, 32'h12345678);
    tick();
    bus1.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(bus1.out_valid), 64'h1);
      chk("hold_pc", 64'(bus1.out_pc), 64'h3004);
      chk("hold_data", 64'(bus1.out_data), 64'h12345678);
`ifdef PIPE_STAGE_REG_SKID_EN
      chk("hold_ready_skid", 64'(bus1.in_ready), 64'h1);
`else
      chk("hold_ready", 64'(bus1.in_ready), 64'h0);
`endif
      tick();
    end
    chk("stall_5", 64'(stall1), 64'd5);
    bus1.out_ready = 1'b1;
    tick();
    chk("release_bubble", 64'(bus1.out_valid), 64'h0);

    // Flush with a held entry and a pending input.
    bus1.out_ready = 1'b0;
    send(32'h3008, 32'h0BAD3008);
    tick();
    chk("pre_flush_pc", 64'(bus1.out_pc), 64'h3008);
    flush = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_pc = 32'h9999;
    bus1.in_data = 32'h99999999;
    #1;
    chk("flush_ready", 64'(bus1.in_ready), 64'h0);
    tick();
    sb.delete();
    flush = 1'b0;
    bus1.in_valid = 1'b0;
    chk("flush_valid", 64'(bus1.out_valid), 64'h0);
    chk("flush_data", 64'(bus1.out_data), 64'h0);
    chk("flush_pc", 64'(bus1.out_pc), 64'h3008);
    chk("flush_stall", 64'(stall1), 64'd5);
    tick();
    chk("flush_no_accept", 64'(bus1.out_valid), 64'h0);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Skid fill and drain.
    send(32'h300C, 32'h0000300C);
    tick();
    chk("skid_ready_1", 64'(bus1.in_ready), 64'h1);
    chk("skid_main_pc", 64'(bus1.out_pc), 64'h300C);
    send(32'h3010, 32'h00003010);
    tick();
    bus1.in_valid = 1'b0;
    chk("skid_full_ready", 64'(bus1.in_ready), 64'h0);
    chk("skid_head_pc", 64'(bus1.out_pc), 64'h300C);
    bus1.in_valid = 1'b1;
    bus1.in_pc = 32'hBAD;
    bus1.in_data = 32'hBAD;
    tick();
    bus1.in_valid = 1'b0;
    chk("skid_full_hold", 64'(bus1.out_pc), 64'h300C);
    bus1.out_ready = 1'b1;
    tick();
    chk("skid_second_valid", 64'(bus1.out_valid), 64'h1);
    chk("skid_second_pc", 64'(bus1.out_pc), 64'h3010);
    chk("skid_ready_back", 64'(bus1.in_ready), 64'h1);
    tick();
    chk("skid_drained", 64'(bus1.out_valid), 64'h0);
    bus1.out_ready = 1'b0;
`else
    // in_ready follows out_ready combinationally when the entry is held.
    send(32'h5100, 32'h00005100);
    tick();
    bus1.in_valid = 1'b1;
    bus1.in_pc = 32'h5104;
    bus1.in_data = 32'h00005104;
    #1;
    chk("comb_ready_0", 64'(bus1.in_ready), 64'h0);
    bus1.out_ready = 1'b1;
    #1;
    chk("comb_ready_1", 64'(bus1.in_ready), 64'h1);
    send(32'h5104, 32'h00005104);
    tick();
    chk("comb_replace_pc", 64'(bus1.out_pc), 64'h5104);
    bus1.in_valid = 1'b0;
    tick();
    chk("comb_drained", 64'(bus1.out_valid), 64'h0);
    bus1.out_ready = 1'b0;
`endif

    // Narrow counter saturation on the second instance.
    bus2.in_valid = 1'b1;
    bus2.in_pc = 32'h5000;
    bus2.in_data = 32'h55;
    tick();
    bus2.in_valid = 1'b0;
    repeat (14) tick();
    chk("sat_14", 64'(stall2), 64'hE);
    tick();
    chk("sat_15", 64'(stall2), 64'hF);
    repeat (5) tick();
    chk("sat_20", 64'(stall2), 64'hF);
    chk("sat_pc", 64'(bus2.out_pc), 64'h5000);

    chk("sb_empty", 64'(sb.size()), 64'h0);

    // Reset dominates flush and clears everything.
    reset = 1'b1;
    flush = 1'b1;
    bus1.in_valid = 1'b1;
    #1;
    chk("rst2_in_ready", 64'(bus1.in_ready), 64'h0);
    tick();
    sb.delete();
    reset = 1'b0;
    flush = 1'b0;
    bus1.in_valid = 1'b0;
    chk("rst2_valid", 64'(bus1.out_valid), 64'h0);
    chk("rst2_pc", 64'(bus1.out_pc), 64'h0);
    chk("rst2_stall", 64'(stall1), 64'h0);
    chk("rst2_stall4", 64'(stall2), 64'h0);
    chk("rst2_pc4", 64'(bus2.out_pc), 64'h0);
    tick();
    monOn = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
